operand_memory_writer: RTL and testbench

OPERAND_MEMORY_WRITER -- requirements
Module: operand_memory_writer

---
 rtl/operand_mem_pkg.sv | 19 +
 rtl/operand_mem_array.sv | 55 +++++
 rtl/operand_memory_writer.sv | 127 ++++++++++++
 tb/tb_operand_memory_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_mem_pkg.sv
// operand_mem_pkg
// Shared constants and FSM state type for the operand memory writer.
//   DATA_W : word width of one operand entry
//   DEPTH  : number of operand entries
//   ADDR_W : address width, clog2(DEPTH)
//   state_t: burst FSM states IDLE, LOAD, DONE
package operand_mem_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/operand_mem_array.sv
// operand_mem_array
// DEPTH x DATA_W operand storage: one synchronous write port and one
// registered read port (latency 1). The array itself is never reset; only
// the read register clears on rst.
// Optional build macro OPERAND_WR_BYPASS_EN: a same-cycle write to the
// address being read is forwarded to the read register (write-first).
// Without it the read returns the old contents (read-before-write).
//   clk, rst            : clock, asynchronous active-high reset
//   i_wr_en/addr/data   : write port
//   i_rd_addr           : read address
//   o_rd_data           : registered read data
module operand_mem_array #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, updated every cycle regardless of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= {DATA_W{1'b0}};
        end else begin
`ifdef OPERAND_WR_BYPASS_EN
            if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[i_rd_addr];
            end
`else
            r_rd_data <= r_mem[i_rd_addr];
`endif
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/operand_memory_writer.sv
// operand_memory_writer
// Loads a burst of 1..16 operand words into operand_mem_array starting at
// start_addr (wrapping at DEPTH-1), and exposes a registered read port for
// the operand consumer.
// Optional build macro OPERAND_WR_BYPASS_EN selects write-first behaviour
// on a same-cycle read/write collision (default: read-before-write).
//   clk, rst          : clock, asynchronous active-high reset
//   start, start_addr : begin a burst at start_addr (ignored unless idle)
//   word_count        : burst length, 0 means DEPTH
//   in_valid, in_data : write word offered
//   in_ready          : high while loading
//   busy, done        : burst in progress / one-cycle completion pulse
//   wr_count          : words accepted in current or last burst
//   rd_addr, rd_value : read address, registered read data (latency 1)
module operand_memory_writer
    import operand_mem_pkg::*;
#(
    parameter  int DATA_W = operand_mem_pkg::DATA_W,
    parameter  int DEPTH  = operand_mem_pkg::DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_value
);

    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W:0]     r_wr_count;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic                w_transfer;

    // in_ready is registered and high exactly in LOAD, so it doubles as the
    // write enable qualifier.
    assign w_transfer = in_valid & r_in_ready;

    // Burst FSM with pointer/counter bookkeeping and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= {ADDR_W{1'b0}};
            r_remaining <= {(ADDR_W+1){1'b0}};
            r_wr_count  <= {(ADDR_W+1){1'b0}};
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_wr_ptr    <= start_addr;
                        r_remaining <= (word_count == {(ADDR_W+1){1'b0}}) ? CNT_DEPTH : word_count;
                        r_wr_count  <= {(ADDR_W+1){1'b0}};
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end else begin
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                LOAD: begin
                    // in_valid low: stall with everything held, no timeout.
                    if (w_transfer) begin
                        r_wr_ptr    <= (r_wr_ptr == PTR_LAST) ? {ADDR_W{1'b0}} : r_wr_ptr + ADDR_W'(1);
                        r_remaining <= r_remaining - CNT_ONE;
                        r_wr_count  <= r_wr_count + CNT_ONE;
                        if (r_remaining == CNT_ONE) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    operand_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_transfer),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_value)
    );

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_operand_memory_writer.sv
module tb_operand_memory_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  start_addr = 4'd0;
    logic [4:0]  word_count = 5'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [4:0]  wr_count;
    logic [3:0]  rd_addr = 4'd0;
    logic [15:0] rd_value;

    int tests = 0;
    int fails = 0;

    // Reference memory: what each address must hold, and whether it was ever written.
    logic [15:0] ref_mem [16];
    bit          known   [16];

    typedef struct {
        logic [3:0]  addr;
        logic [4:0]  cnt;
        int          mode;      // 0 continuous valid, 1 toggle 1,0,1..., 2 random
        logic [15:0] base;      // data = base + i*step when step != 0, else random
        logic [15:0] step;
        int          exp_n;     // expected number of transfers
        bit          mid_start; // pulse start(addr 9) mid-burst
        bit          done_start;// pulse start in the DONE cycle
    } vec_t;

    vec_t vecs [6];

    operand_memory_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .rd_addr    (rd_addr),
        .rd_value   (rd_value)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int          ptr;
        int          acc;
        int          cyc;
        bit          vb;
        logic [15:0] d;
        start = 1'b1; start_addr = v.addr; word_count = v.cnt;
        tick;
        start = 1'b0; start_addr = 4'($urandom);
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);
        check("start_wr_count", wr_count, 0);
        ptr = v.addr; acc = 0; cyc = 0;
        while (acc < v.exp_n && cyc < 200) begin
            case (v.mode)
                0:       vb = 1'b1;
                1:       vb = (cyc % 2 == 0);
                default: vb = 1'($urandom_range(0, 1));
            endcase
            d = (v.step != 16'd0) ? (v.base + 16'(acc) * v.step) : 16'($urandom);
            in_valid = vb; in_data = d;
            if (v.mid_start && acc == 1) begin
                start = 1'b1; start_addr = 4'd9; word_count = 5'd2;
            end
            tick;
            start = 1'b0;
            if (vb) begin
                ref_mem[ptr] = d; known[ptr] = 1'b1;
                ptr = (ptr + 1) % 16;
                acc++;
            end
            cyc++;
            check("wr_count", wr_count, acc);
            if (acc < v.exp_n) begin
                check("load_ready", in_ready, 1);
                check("load_done", done, 0);
            end
        end
        in_valid = 1'b0;
        check("burst_len", acc, v.exp_n);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_ready", in_ready, 0);
        if (v.done_start) begin
            start = 1'b1; start_addr = 4'd9; word_count = 5'd2;
        end
        tick;
        start = 1'b0;
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
        check("final_wr_count", wr_count, v.exp_n);
        tick;
        check("hold_wr_count", wr_count, v.exp_n);
        check("idle_ready", in_ready, 0);
    endtask

    task automatic readback;
        for (int a = 0; a < 16; a++) begin
            if (known[a]) begin
                rd_addr = 4'(a);
                tick;
                check($sformatf("readback[%0d]", a), rd_value, ref_mem[a]);
            end
        end
    endtask

    task automatic read_const(input logic [3:0] a, input logic [15:0] exp);
        rd_addr = a;
        tick;
        check($sformatf("const_read[%0d]", a), rd_value, exp);
    endtask

    initial begin
        vec_t rv;
        for (int a = 0; a < 16; a++) begin
            known[a] = 1'b0;
            ref_mem[a] = 16'd0;
        end
        vecs[0] = '{4'd0,  5'd4,  0, 16'h1111, 16'h1111, 4,  1'b0, 1'b0};
        vecs[1] = '{4'd14, 5'd3,  0, 16'h000A, 16'h0001, 3,  1'b0, 1'b0};
        vecs[2] = '{4'd0,  5'd0,  1, 16'h0000, 16'h0000, 16, 1'b0, 1'b0};
        vecs[3] = '{4'd6,  5'd5,  2, 16'h0000, 16'h0000, 5,  1'b1, 1'b1};
        vecs[4] = '{4'd15, 5'd1,  2, 16'h0000, 16'h0000, 1,  1'b0, 1'b0};
        vecs[5] = '{4'd3,  5'd16, 2, 16'h0000, 16'h0000, 16, 1'b1, 1'b1};

        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_value", rd_value, 0);
        tick; tick;
        rst = 1'b0;
        tick;

        // Table-driven bursts
        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
            if (i == 0) begin
                read_const(4'd0, 16'h1111);
                read_const(4'd1, 16'h2222);
                read_const(4'd2, 16'h3333);
                read_const(4'd3, 16'h4444);
            end
            if (i == 1) begin
                read_const(4'd14, 16'h000A);
                read_const(4'd15, 16'h000B);
                read_const(4'd0,  16'h000C);
            end
            readback;
        end

        // Randomized bursts against the reference model
        for (int i = 0; i < 6; i++) begin
            rv.addr = 4'($urandom);
            rv.cnt = 5'($urandom_range(0, 16));
            rv.mode = 2;
            rv.base = 16'd0;
            rv.step = 16'd0;
            rv.exp_n = (rv.cnt == 5'd0) ? 16 : int'(rv.cnt);
            rv.mid_start = 1'($urandom_range(0, 1));
            rv.done_start = 1'($urandom_range(0, 1));
            run_burst(rv);
            readback;
        end

        // Reset mid-burst: 2 of 5 words written, then rst
        start = 1'b1; start_addr = 4'd10; word_count = 5'd5;
        tick;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick;
            ref_mem[10 + k] = in_data; known[10 + k] = 1'b1;
        end
        in_data = 16'($urandom);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_wr_count", wr_count, 0);
        check("midrst_rd_value", rd_value, 0);
        in_valid = 1'b0;
        tick; tick;
        check("midrst_no_done", done, 0);
        rst = 1'b0;
        tick;
        check("postrst_done", done, 0);
        check("postrst_busy", busy, 0);
        readback;

        // Collision at address 5: seed old value, then read while writing 0xBEEF
        start = 1'b1; start_addr = 4'd5; word_count = 5'd1;
        tick;
        start = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        tick;
        in_valid = 1'b0;
        ref_mem[5] = 16'h1234; known[5] = 1'b1;
        tick; tick;
        start = 1'b1; start_addr = 4'd5; word_count = 5'd1;
        tick;
        start = 1'b0; rd_addr = 4'd5; in_valid = 1'b1; in_data = 16'hBEEF;
        tick;
        in_valid = 1'b0;
`ifdef OPERAND_WR_BYPASS_EN
        check("collision_rd", rd_value, 16'hBEEF);
`else
        check("collision_rd", rd_value, 16'h1234);
`endif
        check("collision_done", done, 1);
        ref_mem[5] = 16'hBEEF;
        tick;
        check("collision_next_rd", rd_value, 16'hBEEF);
        tick;
        readback;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
